// File: rtl/arb3_pkg.sv
// Shared constants for the three-way round-robin arbiter: requester count,
// grant-index width, one-hot FSM state codes and the rotation helper.
package arb3_pkg;

    localparam int N_REQ = 3;
    localparam int ID_W  = 2;

    localparam logic [2:0] ST_IDLE  = 3'b001;
    localparam logic [2:0] ST_GRANT = 3'b010;
    localparam logic [2:0] ST_GAP   = 3'b100;

    // Next requester index in rotation order, wrapping 2 -> 0.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id >= ID_W'(N_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin winner picker: scans last+1, last+2, last+3
// (mod 3) and returns the first active requester.
module rr_pick3
    import arb3_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic             valid,
    output logic [ID_W-1:0]  id
);

    logic [ID_W-1:0] cand;

    // Walk the rotation once; the earliest active candidate wins.
    always_comb begin
        // NOTE: blocking assignments here so each loop pass sees the updated
        // candidate and the "already found" flag from the previous pass.
        valid = 1'b0;
        id    = '0;
        cand  = last;
        for (int k = 0; k < N_REQ; k++) begin
            cand = next_id(cand);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                id    = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter3.sv
// Three-requester round-robin arbiter for a shared datapath unit. Grants are
// held until the owner drops its request, followed by one idle GAP cycle.
// Optional forced revocation after HOLD_MAX cycles: define ARB3_TIMEOUT_EN.
module rr_arbiter3
    import arb3_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout
);

    // Reject configurations the hold counter cannot represent.
    if (HOLD_MAX < 2 || (1 << CNT_W) <= HOLD_MAX) begin : g_bad_cfg
        $error("rr_arbiter3: need HOLD_MAX >= 2 and 2**CNT_W > HOLD_MAX");
    end

    logic [2:0]       state_q, state_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             busy_q, busy_d;
    logic             pick_valid;
    logic [ID_W-1:0]  pick_id;
`ifdef ARB3_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    // Single picker shared by the IDLE and GAP transitions.
    rr_pick3 u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .id    (pick_id)
    );

    // Next-state and next-output logic for the grant FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        busy_d   = busy_q;
`ifdef ARB3_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (pick_valid) begin
                    state_d  = ST_GRANT;
                    gnt_d    = N_REQ'(1) << pick_id;
                    gnt_id_d = pick_id;
                    last_d   = pick_id;
                    busy_d   = 1'b1;
`ifdef ARB3_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req[gnt_id_q]) begin
                    state_d = ST_GAP;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
`ifdef ARB3_TIMEOUT_EN
                else if (cnt_q == CNT_W'(HOLD_MAX - 1)) begin
                    // Owner has held the unit HOLD_MAX cycles: revoke it.
                    state_d   = ST_GAP;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                // Illegal one-hot code: recover to IDLE with the unit released.
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM state, rotation pointer and hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= ID_W'(N_REQ - 1);
`ifdef ARB3_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so all flops update together
            // from pre-edge values, independent of statement order.
            state_q <= state_d;
            last_q  <= last_d;
`ifdef ARB3_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
`ifdef ARB3_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
`ifdef ARB3_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;
`ifdef ARB3_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter3.sv
// Testbench for rr_arbiter3: directed and random request patterns, with a
// behavioural owner/pointer model feeding a scoreboard queue that a separate
// monitor drains one entry per clock.
module tb_rr_arbiter3;

    localparam int HOLD_MAX = 4;
    localparam int CNT_W    = 3;
`ifdef ARB3_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       timeout;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    exp_t sb[$];
    int   checks;
    int   errors;

    // Reference model: who owns the unit, whose turn was last, for how long.
    int   m_owner;   // -1 when nobody holds a grant
    int   m_last;
    int   m_id;
    int   m_held;
    bit   m_timeout;

    rr_arbiter3 #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_last    = 2;
        m_id      = 0;
        m_held    = 0;
        m_timeout = 1'b0;
    endtask

    // One clock of arbitration as the rules describe it. A free unit (after
    // idle or after the handoff cycle) is offered in rotation order from the
    // last winner; a released or revoked unit is always free for one cycle.
    task automatic model_step(input logic [2:0] r);
        int win;
        m_timeout = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1;
            end else if (TO_EN && m_held == HOLD_MAX) begin
                m_owner   = -1;
                m_timeout = 1'b1;
            end else begin
                m_held++;
            end
        end else begin
            win = -1;
            for (int k = 1; k <= 3; k++) begin
                if (win < 0 && r[(m_last + k) % 3]) win = (m_last + k) % 3;
            end
            if (win >= 0) begin
                m_owner = win;
                m_last  = win;
                m_id    = win;
                m_held  = 1;
            end
        end
    endtask

    // Apply one request vector for the coming edge and queue the expectation.
    task automatic drive(input logic [2:0] r);
        exp_t e;
        @(negedge clk);
        req = r;
        model_step(r);
        e.gnt     = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        e.id      = 2'(m_id);
        e.busy    = (m_owner >= 0);
        e.timeout = m_timeout;
        sb.push_back(e);
    endtask

    // Reset at a negedge (scoreboard empty there) and check the async clear.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'(0));
        check("async_rst_busy", 32'(busy), 32'(0));
        model_reset();
        req = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_gnt_id", 32'(gnt_id), 32'(0));
        check("rst_timeout", 32'(timeout), 32'(0));
    endtask

    // Monitor: one registered output set per clock, compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("gnt", 32'(gnt), 32'(e.gnt));
                check("gnt_id", 32'(gnt_id), 32'(e.id));
                check("busy", 32'(busy), 32'(e.busy));
                check("timeout", 32'(timeout), 32'(e.timeout));
            end
        end
    end

    // Watchdog against a stuck run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] r;
        checks = 0;
        errors = 0;
        model_reset();
        rst_n = 1'b0;
        req   = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_gnt_id", 32'(gnt_id), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_timeout", 32'(timeout), 32'(0));

        // Single requester, then release into GAP and IDLE.
        repeat (5) drive(3'b001);
        repeat (4) drive(3'b000);

        // Everyone requesting, owner never lets go.
        repeat (30) drive(3'b111);
        repeat (3) drive(3'b000);

        // All requesting; each owner releases after 3 granted cycles and
        // re-requests right away.
        repeat (40) begin
            r = 3'b111;
            if (m_owner >= 0 && m_held >= 3) r[m_owner] = 1'b0;
            drive(r);
        end
        repeat (3) drive(3'b000);

        // Reset in the middle of a grant, then 110 takes id 1 first.
        repeat (3) drive(3'b010);
        do_reset();
        repeat (3) drive(3'b110);
        repeat (3) drive(3'b000);

        // Owner 1 releases while 0 waits; 1 reasserting in the GAP loses.
        do_reset();
        repeat (2) drive(3'b010);
        repeat (2) drive(3'b011);
        drive(3'b001);
        repeat (3) drive(3'b011);
        repeat (3) drive(3'b000);

        // Random traffic, biased so owners tend to keep their request.
        repeat (400) begin
            r = 3'($urandom_range(0, 7));
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            drive(r);
        end
        repeat (3) drive(3'b000);

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
